// File: rtl/bsg_cgol_host_driver.sv
// Purpose: serialize a parallel (board, frames) request into the core's 64-bit word stream, then gather the result words into a parallel board.
// Latency: first word one cycle after start is accepted; done_v_o one cycle after the last result word is accepted.
// Backpressure: send words hold while ready_i is low; start is only taken in IDLE; the response holds until done_yumi_i.
module bsg_cgol_host_driver #(
    // Overridden per instance; the defaults only give a standalone build a legal shape.
    parameter int board_width_p     = 8,
    parameter int max_game_length_p = 16,
    localparam int num_total_cells_lp   = board_width_p * board_width_p,
    localparam int game_length_width_lp = ((max_game_length_p + 1) <= 1) ? 1 : $clog2(max_game_length_p + 1),
    localparam int words_lp             = (num_total_cells_lp + 63) / 64,
    localparam int cnt_width_lp         = ((words_lp + 1) <= 1) ? 1 : $clog2(words_lp + 1)
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [num_total_cells_lp-1:0]   board_i,
    input  logic [game_length_width_lp-1:0] frames_i,
    input  logic                            start_v_i,
    output logic                            start_ready_o,
    output logic [63:0]                     data_o,
    output logic                            v_o,
    input  logic                            ready_i,
    input  logic [63:0]                     data_i,
    input  logic                            v_i,
    output logic                            yumi_o,
    output logic [num_total_cells_lp-1:0]   board_o,
    output logic                            done_v_o,
    input  logic                            done_yumi_i
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SEND_FRAMES = 3'd1,
        SEND_CELLS  = 3'd2,
        RECV        = 3'd3,
        DONE        = 3'd4
    } state_e;

    localparam logic [cnt_width_lp-1:0]         last_word_lp  = cnt_width_lp'(words_lp - 1);
    localparam logic [game_length_width_lp-1:0] max_frames_lp = game_length_width_lp'(max_game_length_p);

    state_e                          state_q,  state_d;
    logic [cnt_width_lp-1:0]         cnt_q,    cnt_d;
    logic [game_length_width_lp-1:0] frames_q, frames_d;
    logic [num_total_cells_lp-1:0]   cells_q,  cells_d;
    logic [num_total_cells_lp-1:0]   board_q,  board_d;

    logic [words_lp*64-1:0]          cells_pad;
    logic [63:0]                     cell_word;

    // Select the outgoing cell word; bits past the last cell come out as zero.
    always_comb begin
        cells_pad = '0;
        cells_pad[num_total_cells_lp-1:0] = cells_q;
        cell_word = '0;
        for (int k = 0; k < words_lp; k++) begin
            if (cnt_q == cnt_width_lp'(k)) begin
                cell_word = cells_pad[k*64 +: 64];
            end
        end
    end

    // Next-state, counter, request latch and result assembly.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        frames_d = frames_q;
        cells_d  = cells_q;
        board_d  = board_q;
        case (state_q)
            IDLE: begin
                if (start_v_i) begin
                    frames_d = (frames_i > max_frames_lp) ? max_frames_lp : frames_i;
                    cells_d  = board_i;
                    cnt_d    = '0;
                    state_d  = SEND_FRAMES;
                end
            end
            SEND_FRAMES: begin
                if (ready_i) begin
                    state_d = SEND_CELLS;
                end
            end
            SEND_CELLS: begin
                if (ready_i) begin
                    if (cnt_q == last_word_lp) begin
                        cnt_d   = '0;
                        state_d = RECV;
                    end else begin
                        cnt_d = cnt_q + cnt_width_lp'(1);
                    end
                end
            end
            RECV: begin
                if (v_i) begin
                    // Only cells that exist are written; padding bits of the last word fall away.
                    for (int i = 0; i < num_total_cells_lp; i++) begin
                        if (cnt_q == cnt_width_lp'(i / 64)) begin
                            board_d[i] = data_i[i % 64];
                        end
                    end
                    if (cnt_q == last_word_lp) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + cnt_width_lp'(1);
                    end
                end
            end
            DONE: begin
                if (done_yumi_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any transaction and clears the result.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            frames_q <= '0;
            cells_q  <= '0;
            board_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            frames_q <= frames_d;
            cells_q  <= cells_d;
            board_q  <= board_d;
        end
    end

    // Outputs decode registered state only, except yumi_o which follows v_i in RECV.
    always_comb begin
        start_ready_o = (state_q == IDLE);
        v_o           = (state_q == SEND_FRAMES) || (state_q == SEND_CELLS);
        done_v_o      = (state_q == DONE);
        yumi_o        = (state_q == RECV) && v_i;
        board_o       = board_q;
        case (state_q)
            SEND_FRAMES: data_o = 64'(frames_q);
            SEND_CELLS:  data_o = cell_word;
            default:     data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_bsg_cgol_host_driver.sv
// Purpose: randomized and directed check of bsg_cgol_host_driver (100-cell board, two words per board) against a scoreboard.
// Latency: expects the frame word one cycle after start and done_v_o one cycle after the last result word.
// Backpressure: ready_i stalls on the send side, v_i gaps on the receive side, delayed done_yumi_i.
module tb_bsg_cgol_host_driver;

    localparam int N     = 100;
    localparam int WORDS = 2;
    localparam int MAXF  = 16;

    logic           clk_i;
    logic           reset_n_i;
    logic [N-1:0]   board_i;
    logic [4:0]     frames_i;
    logic           start_v_i;
    logic           start_ready_o;
    logic [63:0]    data_o;
    logic           v_o;
    logic           ready_i;
    logic [63:0]    data_i;
    logic           v_i;
    logic           yumi_o;
    logic [N-1:0]   board_o;
    logic           done_v_o;
    logic           done_yumi_i;

    bsg_cgol_host_driver #(
        .board_width_p     (10),
        .max_game_length_p (MAXF)
    ) dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .board_i       (board_i),
        .frames_i      (frames_i),
        .start_v_i     (start_v_i),
        .start_ready_o (start_ready_o),
        .data_o        (data_o),
        .v_o           (v_o),
        .ready_i       (ready_i),
        .data_i        (data_i),
        .v_i           (v_i),
        .yumi_o        (yumi_o),
        .board_o       (board_o),
        .done_v_o      (done_v_o),
        .done_yumi_i   (done_yumi_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    logic [63:0]  exp_tx[$];
    logic [N-1:0] exp_rsp[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: frame word is the clamped count; cell words are the board cut into 64-bit slices, zero beyond cell 99.
    function automatic logic [63:0] ref_frame(input logic [4:0] fr);
        int f;
        f = int'(fr);
        if (f > MAXF) f = MAXF;
        return 64'(f);
    endfunction

    function automatic logic [63:0] ref_cell(input logic [N-1:0] b, input int k);
        logic [127:0] p;
        p = 128'(b);
        return p[k*64 +: 64];
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic push_expect(input logic [N-1:0] brd, input logic [4:0] fr, input logic [127:0] res);
        exp_tx.push_back(ref_frame(fr));
        for (int k = 0; k < WORDS; k++) exp_tx.push_back(ref_cell(brd, k));
        exp_rsp.push_back(res[N-1:0]);
    endtask

    // Monitor: pops the scoreboard on every send transfer and on each rising done_v_o.
    logic [63:0] prev_data;
    bit          stall_prev = 0;
    bit          done_prev  = 0;
    always @(negedge clk_i) begin
        if (!reset_n_i) begin
            stall_prev = 0;
            done_prev  = 0;
        end else begin
            if (v_o && stall_prev) chk("stall_hold", 128'(data_o), 128'(prev_data));
            if (v_o && ready_i) begin
                if (exp_tx.size() == 0) chk("tx_unexpected", 128'(data_o), 128'(0));
                else chk("tx_word", 128'(data_o), 128'(exp_tx.pop_front()));
            end
            stall_prev = v_o && !ready_i;
            prev_data  = data_o;
            if (done_v_o && !done_prev) begin
                if (exp_rsp.size() == 0) chk("rsp_unexpected", 128'(done_v_o), 128'(0));
                else chk("rsp_board", 128'(board_o), 128'(exp_rsp.pop_front()));
            end
            done_prev = done_v_o;
        end
    end

    task automatic start_phase(input logic [N-1:0] brd, input logic [4:0] fr);
        int budget;
        budget = 20;
        while (!start_ready_o && budget > 0) begin
            @(posedge clk_i); #1;
            budget--;
        end
        chk("start_ready", 128'(start_ready_o), 128'(1));
        start_v_i = 1'b1;
        board_i   = brd;
        frames_i  = fr;
        @(posedge clk_i); #1;
        start_v_i = 1'b0;
        @(negedge clk_i);
        chk("first_word_latency", 128'(v_o), 128'(1));
        @(posedge clk_i); #1;
    endtask

    // Core ready side: each word is refused for 'stall' cycles before acceptance; junk on v_i must be ignored.
    task automatic send_phase(input int stall);
        int sent, iters, wait_cnt;
        sent = 0; iters = 0; wait_cnt = 0;
        v_i    = 1'b1;
        data_i = {$urandom, $urandom};
        while (sent < WORDS + 1 && iters < 200) begin
            ready_i = (wait_cnt >= stall);
            @(negedge clk_i);
            chk("yumi_outside_recv", 128'(yumi_o), 128'(0));
            if (v_o && ready_i) begin
                sent++;
                wait_cnt = 0;
            end else if (v_o) begin
                wait_cnt++;
            end
            @(posedge clk_i); #1;
            iters++;
        end
        ready_i = 1'b0;
        v_i     = 1'b0;
        chk("send_word_count", 128'(sent), 128'(WORDS + 1));
        chk("send_cycles", 128'(iters), 128'((WORDS + 1) * (stall + 1)));
    endtask

    task automatic recv_phase(input logic [127:0] res, input int maxgap);
        for (int k = 0; k < WORDS; k++) begin
            int gap;
            gap = $urandom_range(0, maxgap);
            v_i = 1'b0;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk_i);
                chk("recv_gap_yumi", 128'(yumi_o), 128'(0));
                chk("recv_gap_v_o", 128'(v_o), 128'(0));
                @(posedge clk_i); #1;
            end
            v_i    = 1'b1;
            data_i = res[k*64 +: 64];
            @(negedge clk_i);
            chk("yumi_recv", 128'(yumi_o), 128'(1));
            chk("done_early", 128'(done_v_o), 128'(0));
            @(posedge clk_i); #1;
        end
        v_i = 1'b0;
        @(negedge clk_i);
        chk("done_timing", 128'(done_v_o), 128'(1));
        @(posedge clk_i); #1;
    endtask

    task automatic done_phase(input int delay, input bit hold, input logic [N-1:0] nb,
                              input logic [4:0] nf, input logic [127:0] res);
        if (hold) begin
            start_v_i = 1'b1;
            board_i   = nb;
            frames_i  = nf;
        end
        for (int i = 0; i < delay; i++) begin
            @(negedge clk_i);
            chk("done_held", 128'(done_v_o), 128'(1));
            chk("busy_not_ready", 128'(start_ready_o), 128'(0));
            chk("busy_no_send", 128'(v_o), 128'(0));
            @(posedge clk_i); #1;
        end
        done_yumi_i = 1'b1;
        @(posedge clk_i); #1;
        done_yumi_i = 1'b0;
        @(negedge clk_i);
        chk("ready_after_done", 128'(start_ready_o), 128'(1));
        chk("done_dropped", 128'(done_v_o), 128'(0));
        chk("board_hold", 128'(board_o), 128'(res[N-1:0]));
        @(posedge clk_i); #1;
        if (hold) begin
            start_v_i = 1'b0;
            @(negedge clk_i);
            chk("b2b_first_word", 128'(v_o), 128'(1));
            @(posedge clk_i); #1;
        end
    endtask

    task automatic run_txn(input logic [N-1:0] brd, input logic [4:0] fr, input int stall,
                           input logic [127:0] res, input int gap, input int delay);
        push_expect(brd, fr, res);
        start_phase(brd, fr);
        send_phase(stall);
        recv_phase(res, gap);
        done_phase(delay, 1'b0, '0, '0, res);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ra, rb, res;
        logic [N-1:0] ba, bb;

        reset_n_i = 1'b0; start_v_i = 1'b0; board_i = '0; frames_i = '0;
        ready_i = 1'b0; data_i = '0; v_i = 1'b0; done_yumi_i = 1'b0;
        #2;
        chk("reset_v_o", 128'(v_o), 128'(0));
        chk("reset_data_o", 128'(data_o), 128'(0));
        chk("reset_done", 128'(done_v_o), 128'(0));
        chk("reset_board", 128'(board_o), 128'(0));
        chk("reset_start_ready", 128'(start_ready_o), 128'(1));
        #20 reset_n_i = 1'b1;
        @(posedge clk_i); #1;

        // Basic small board pattern, full rate.
        run_txn(N'(64'h0000_0000_0000_0E00), 5'd5, 0, 128'h0000_0000_0004_0400, 0, 0);

        // All-ones board, clamp 31 -> 16, 3-cycle stall per word, padding on the return.
        res = {128{1'b1}};
        run_txn({N{1'b1}}, 5'd31, 3, res, 0, 1);
        chk("padding_high_cells", 128'(board_o[99:64]), 128'({36{1'b1}}));

        // Back-to-back with start_v_i held across done_yumi_i.
        ra = rand128(); rb = rand128();
        ba = rand128(); bb = rand128();
        push_expect(ba, 5'd9, ra);
        start_phase(ba, 5'd9);
        send_phase(1);
        recv_phase(ra, 1);
        push_expect(bb, 5'd17, rb);
        done_phase(2, 1'b1, bb, 5'd17, ra);
        send_phase(0);
        recv_phase(rb, 0);
        done_phase(0, 1'b0, '0, '0, rb);

        // Reset between edges after the first of two result words.
        ra = rand128(); ba = rand128();
        exp_tx.push_back(ref_frame(5'd3));
        for (int k = 0; k < WORDS; k++) exp_tx.push_back(ref_cell(ba, k));
        start_phase(ba, 5'd3);
        send_phase(0);
        v_i = 1'b1; data_i = ra[63:0];
        @(negedge clk_i);
        chk("yumi_word0", 128'(yumi_o), 128'(1));
        @(posedge clk_i); #1;
        chk("partial_word0", 128'(board_o[63:0]), 128'(ra[63:0]));
        data_i = ra[127:64];
        #2 reset_n_i = 1'b0;
        #1;
        chk("midreset_v_o", 128'(v_o), 128'(0));
        chk("midreset_yumi", 128'(yumi_o), 128'(0));
        chk("midreset_done", 128'(done_v_o), 128'(0));
        chk("midreset_board", 128'(board_o), 128'(0));
        chk("midreset_data", 128'(data_o), 128'(0));
        chk("midreset_ready", 128'(start_ready_o), 128'(1));
        v_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #3 reset_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("no_partial_done", 128'(done_v_o), 128'(0));
        end
        @(posedge clk_i); #1;
        run_txn(N'(rand128()), 5'd1, 0, rand128(), 0, 0);

        // Randomized transactions.
        for (int t = 0; t < 10; t++) begin
            run_txn(N'(rand128()), 5'($urandom_range(0, 31)), $urandom_range(0, 3),
                    rand128(), 2, $urandom_range(0, 2));
        end

        repeat (3) @(posedge clk_i);
        #1;
        chk("tx_queue_drained", 128'(exp_tx.size()), 128'(0));
        chk("rsp_queue_drained", 128'(exp_rsp.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
